// File: rtl/hififo_pkg.sv
// Shared constants for the host-to-FPGA DMA channel.
// Block geometry, PIO register offsets and pointer width helper.
package hififo_pkg;

  localparam int BLOCK_BYTES  = 512;
  localparam int BLOCK_QWORDS = 64;
  localparam int INDEX_W      = 6;

  localparam int PIO_STOP  = 0;
  localparam int PIO_INT   = 1;
  localparam int PIO_FLUSH = 2;
  localparam int PIO_PT    = 32;

  function automatic int ptr_width(
    input int pt_bits,
    input int page_bits
  );
    return pt_bits + page_bits - $clog2(BLOCK_BYTES);
  endfunction

endpackage

// File: rtl/hififo_gray_sync.sv
// Pointer crossing: binary->gray register in the source domain,
// 2-flop sync and gray->binary in the destination domain.
// Ports: src_clock/src_reset/bin_in, dst_clock/dst_reset/bin_out.
module hififo_gray_sync #(
  parameter int WIDTH = 4
) (
  input  logic             src_clock,
  input  logic             src_reset,
  input  logic [WIDTH-1:0] bin_in,
  input  logic             dst_clock,
  input  logic             dst_reset,
  output logic [WIDTH-1:0] bin_out
);

  logic [WIDTH-1:0] gray_src;
  logic [WIDTH-1:0] gray_s1;
  logic [WIDTH-1:0] gray_s2;

  always_ff @(posedge src_clock) begin
    if (src_reset) gray_src <= '0;
    else gray_src <= bin_in ^ (bin_in >> 1);
  end

  always_ff @(posedge dst_clock) begin
    if (dst_reset) begin
      gray_s1 <= '0;
      gray_s2 <= '0;
    end else begin
      gray_s1 <= gray_src;
      gray_s2 <= gray_s1;
    end
  end

  always_comb begin
    bin_out = '0;
    for (int i = 0; i < WIDTH; i++)
      bin_out[i] = ^(gray_s2 >> i);
  end

endmodule

// File: rtl/hififo_fpc_fifo_p.sv
// Host-to-FPGA DMA channel: page-table driven 512-byte read requests,
// out-of-order completion reassembly into a BRAM ring, and a 64-bit
// consumer port on fifo_clock.
// Ports: clock/reset (sync, active-high), interrupt, status,
//   pio_* register writes, rc_* completions, rr_* read requests,
//   fifo_clock/fifo_read/fifo_read_data/fifo_read_valid.
// Optional: define HIFIFO_FPC_TAG_CHECK_EN to drop completions for
//   tags that are not outstanding and raise a sticky error.
module hififo_fpc_fifo_p
  import hififo_pkg::*;
#(
  parameter int          LOG2_BLOCKS = 3,
  parameter int          TAG_BASE    = 0,
  parameter int          PT_BITS     = 5,
  parameter int          PAGE_BITS   = 21,
  parameter logic [12:0] PIO_BASE    = 13'h010
) (
  input  logic        clock,
  input  logic        reset,
  output logic [1:0]  interrupt,
  output logic [63:0] status,
  input  logic        pio_wvalid,
  input  logic [12:0] pio_addr,
  input  logic [63:0] pio_wdata,
  input  logic        rc_valid,
  input  logic [7:0]  rc_tag,
  input  logic [5:0]  rc_index,
  input  logic [63:0] rc_data,
  output logic        rr_valid,
  output logic [63:0] rr_addr,
  output logic [7:0]  rr_tag,
  input  logic        rr_ready,
  input  logic        fifo_clock,
  input  logic        fifo_read,
  output logic [63:0] fifo_read_data,
  output logic        fifo_read_valid
);

  localparam int BLOCKS   = 1 << LOG2_BLOCKS;
  localparam int PW       = ptr_width(PT_BITS, PAGE_BITS);
  localparam int AW       = LOG2_BLOCKS + INDEX_W;
  localparam int RW       = PW + INDEX_W;
  localparam int PTW      = 64 - PAGE_BITS;
  localparam int MASK_LEN = BLOCKS + 16;
  localparam int MW       = $clog2(MASK_LEN + 1);
  localparam logic [7:0] TAG_B = 8'(TAG_BASE);
  localparam logic [INDEX_W-1:0] LAST_IDX =
    INDEX_W'(BLOCK_QWORDS - 1);

  logic [PW-1:0]     p_request;
  logic [PW-1:0]     p_write;
  logic [PW-1:0]     p_read;
  logic [PW-1:0]     p_stop;
  logic [PW-1:0]     p_int;
  logic [BLOCKS-1:0] filled;
  logic [BLOCKS-1:0] filled_next;
  logic              req_hold;
  logic [MW-1:0]     mask_cnt;
  logic [PTW-1:0]    pt [1 << PT_BITS];
  logic [PTW-1:0]    pt_q;
  logic [63:0]       bram [1 << AW];
  logic              err_bit;
  logic              unused_bits;

  // PIO decode
  logic [12:0] pio_off;
  logic [12:0] pt_off;
  logic        wr_stop;
  logic        wr_int;
  logic        flush;
  logic        wr_pt;

  assign pio_off = pio_addr - PIO_BASE;
  assign pt_off  = pio_off - 13'(PIO_PT);
  assign wr_stop = pio_wvalid && pio_off == 13'(PIO_STOP);
  assign wr_int  = pio_wvalid && pio_off == 13'(PIO_INT);
  assign flush   = pio_wvalid && pio_off == 13'(PIO_FLUSH)
                   && pio_wdata[0];
  assign wr_pt   = pio_wvalid && pio_off >= 13'(PIO_PT)
                   && pt_off < 13'(1 << PT_BITS);
  assign unused_bits = ^pio_wdata[8:1];

  // Request side
  logic [PW-1:0] in_flight;
  logic          rr_fire;

  assign in_flight = p_request - p_read;
  assign rr_valid  = !req_hold && p_request != p_stop
                     && in_flight < PW'(BLOCKS - 1);
  assign rr_fire   = rr_valid && rr_ready;
  assign rr_tag    = TAG_B + 8'(p_request[LOG2_BLOCKS-1:0]);
  assign rr_addr   = {pt_q, p_request[PAGE_BITS-10:0], 9'd0};

  // pt_q lags p_request by one cycle; req_hold covers that gap.
  always_ff @(posedge clock) begin
    if (wr_pt) pt[pt_off[PT_BITS-1:0]] <= pio_wdata[63:PAGE_BITS];
    pt_q <= pt[p_request[PW-1:PAGE_BITS-9]];
  end

  // Completion side
  logic                   rc_ours;
  logic                   rc_take;
  logic [LOG2_BLOCKS-1:0] rc_low;
  logic [LOG2_BLOCKS-1:0] w_low;
  logic                   commit;

  assign rc_ours = rc_valid
    && rc_tag[7:LOG2_BLOCKS] == TAG_B[7:LOG2_BLOCKS];
  assign rc_low  = rc_tag[LOG2_BLOCKS-1:0];
  assign w_low   = p_write[LOG2_BLOCKS-1:0];
  assign commit  = filled[w_low];

`ifdef HIFIFO_FPC_TAG_CHECK_EN
  logic                   err;
  logic [LOG2_BLOCKS-1:0] rc_rel;
  logic [PW-1:0]          pend;
  logic                   rc_known;

  assign rc_rel   = rc_low - w_low;
  assign pend     = p_request - p_write;
  assign rc_known = PW'(rc_rel) < pend;
  assign rc_take  = rc_ours && rc_known;
  assign err_bit  = err;

  always_ff @(posedge clock) begin
    if (reset || flush) err <= 1'b0;
    else if (rc_ours && !rc_known) err <= 1'b1;
  end
`else
  assign rc_take = rc_ours;
  assign err_bit = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (rc_take) bram[{rc_low, rc_index}] <= rc_data;
  end

  // Late beats of a flushed request must not mark blocks filled.
  always_comb begin
    filled_next = filled;
    if (commit) filled_next[w_low] = 1'b0;
    if (rc_take && rc_index == LAST_IDX && mask_cnt == '0)
      filled_next[rc_low] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      p_stop    <= '0;
      p_int     <= '0;
      p_request <= '0;
      p_write   <= '0;
      filled    <= '0;
      req_hold  <= 1'b1;
      mask_cnt  <= '0;
      interrupt <= '0;
    end else begin
      if (wr_stop) p_stop <= pio_wdata[PW+8:9];
      if (wr_int) p_int <= pio_wdata[PW+8:9];
      if (flush) begin
        p_request <= '0;
        p_write   <= '0;
        filled    <= '0;
        req_hold  <= 1'b1;
        mask_cnt  <= MW'(MASK_LEN);
        interrupt <= '0;
      end else begin
        if (rr_fire) p_request <= p_request + 1'b1;
        if (commit) p_write <= p_write + 1'b1;
        req_hold <= rr_fire;
        filled   <= filled_next;
        if (mask_cnt != '0) mask_cnt <= mask_cnt - MW'(1);
        interrupt <= {(p_write == p_stop) | err_bit,
                      p_write == p_int};
      end
    end
  end

  assign status = {err_bit, {(63 - 2 * PW){1'b0}}, p_read, p_write};

  // Consumer-domain clear: stretched over the flush mask window so a
  // slow fifo_clock still sees it.
  logic fifo_clr_src;
  logic rd_clr;
  logic rst_s1;
  logic rst_s2;

  assign rd_clr = reset || flush || mask_cnt != '0;

  always_ff @(posedge clock) begin
    fifo_clr_src <= rd_clr;
  end

  always_ff @(posedge fifo_clock) begin
    rst_s1 <= fifo_clr_src;
    rst_s2 <= rst_s1;
  end

  logic [PW-1:0] p_write_sync;
  logic [RW-1:0] rd_ptr;
  logic          rd_accept;
  logic          v1;
  logic [63:0]   mem_q;

  hififo_gray_sync #(.WIDTH(PW)) u_wr_sync (
    .src_clock (clock),
    .src_reset (reset || flush),
    .bin_in    (p_write),
    .dst_clock (fifo_clock),
    .dst_reset (rst_s2),
    .bin_out   (p_write_sync)
  );

  hififo_gray_sync #(.WIDTH(PW)) u_rd_sync (
    .src_clock (fifo_clock),
    .src_reset (rst_s2),
    .bin_in    (rd_ptr[RW-1:INDEX_W]),
    .dst_clock (clock),
    .dst_reset (rd_clr),
    .bin_out   (p_read)
  );

  assign rd_accept = fifo_read
    && rd_ptr != {p_write_sync, INDEX_W'(0)};

  always_ff @(posedge fifo_clock) begin
    if (rst_s2) begin
      rd_ptr          <= '0;
      v1              <= 1'b0;
      fifo_read_valid <= 1'b0;
    end else begin
      if (rd_accept) rd_ptr <= rd_ptr + 1'b1;
      v1              <= rd_accept;
      fifo_read_valid <= v1;
    end
  end

  always_ff @(posedge fifo_clock) begin
    if (rd_accept) mem_q <= bram[rd_ptr[AW-1:0]];
    if (v1) fifo_read_data <= mem_q;
  end

endmodule

// File: tb/tb_hififo_fpc_fifo_p.sv
// Scoreboard bench for hififo_fpc_fifo_p: request and fifo monitors
// pop expected values queued by the directed stimulus.
module tb_hififo_fpc_fifo_p;

  localparam logic [12:0] PB = 13'h010;

  logic        clock = 0;
  logic        reset;
  logic [1:0]  interrupt;
  logic [63:0] status;
  logic        pio_wvalid;
  logic [12:0] pio_addr;
  logic [63:0] pio_wdata;
  logic        rc_valid;
  logic [7:0]  rc_tag;
  logic [5:0]  rc_index;
  logic [63:0] rc_data;
  logic        rr_valid;
  logic [63:0] rr_addr;
  logic [7:0]  rr_tag;
  logic        rr_ready;
  logic        fifo_clock = 0;
  logic        fifo_read;
  logic [63:0] fifo_read_data;
  logic        fifo_read_valid;

  hififo_fpc_fifo_p dut (
    .clock           (clock),
    .reset           (reset),
    .interrupt       (interrupt),
    .status          (status),
    .pio_wvalid      (pio_wvalid),
    .pio_addr        (pio_addr),
    .pio_wdata       (pio_wdata),
    .rc_valid        (rc_valid),
    .rc_tag          (rc_tag),
    .rc_index        (rc_index),
    .rc_data         (rc_data),
    .rr_valid        (rr_valid),
    .rr_addr         (rr_addr),
    .rr_tag          (rr_tag),
    .rr_ready        (rr_ready),
    .fifo_clock      (fifo_clock),
    .fifo_read       (fifo_read),
    .fifo_read_data  (fifo_read_data),
    .fifo_read_valid (fifo_read_valid)
  );

  always #5 clock = ~clock;
  always #7 fifo_clock = ~fifo_clock;

  int total = 0;
  int bad = 0;
  int req_seen = 0;
  logic [71:0] exp_rr[$];
  logic [63:0] exp_fifo[$];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] word(input int n, input int i);
    return {16'hCAFE, 16'(n), 16'(i), 16'h5A5A};
  endfunction

  task automatic expect_req(input int n);
    exp_rr.push_back({8'(n % 8),
                      64'h1_0000_0000 + 64'(n) * 64'h200});
  endtask

  task automatic expect_block(input int n);
    for (int i = 0; i < 64; i++) exp_fifo.push_back(word(n, i));
  endtask

  always @(negedge clock) begin
    if (rr_valid && rr_ready) begin
      req_seen++;
      if (exp_rr.size() == 0)
        chk("rr_unexpected", {rr_tag, rr_addr}, 64'h0);
      else
        chk("rr_req", {rr_tag, rr_addr}, exp_rr.pop_front());
    end
  end

  always @(negedge fifo_clock) begin
    if (fifo_read_valid) begin
      if (exp_fifo.size() == 0)
        chk("fifo_unexpected", fifo_read_data, 64'hx);
      else
        chk("fifo_data", fifo_read_data, exp_fifo.pop_front());
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic pio_write(input int off, input logic [63:0] d);
    @(posedge clock) #1;
    pio_wvalid = 1;
    pio_addr = PB + 13'(off);
    pio_wdata = d;
    @(posedge clock) #1;
    pio_wvalid = 0;
  endtask

  task automatic send_beat(input int tag, input int idx,
                           input logic [63:0] d);
    @(posedge clock) #1;
    rc_valid = 1;
    rc_tag = 8'(tag);
    rc_index = 6'(idx);
    rc_data = d;
    @(posedge clock) #1;
    rc_valid = 0;
  endtask

  task automatic send_block(input int n, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      @(posedge clock) #1;
      rc_valid = 1;
      rc_tag = 8'(n % 8);
      rc_index = 6'(i);
      rc_data = word(n, i);
    end
    @(posedge clock) #1;
    rc_valid = 0;
  endtask

  task automatic set_read(input logic v);
    @(posedge fifo_clock) #1;
    fifo_read = v;
  endtask

  task automatic read_n(input int n);
    @(posedge fifo_clock) #1;
    fifo_read = 1;
    repeat (n) @(posedge fifo_clock);
    #1;
    fifo_read = 0;
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 3000 && exp_fifo.size() != 0; k++)
      @(posedge fifo_clock);
    chk(name, 64'(exp_fifo.size()), 64'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    reset = 1;
    pio_wvalid = 0;
    pio_addr = 0;
    pio_wdata = 0;
    rc_valid = 0;
    rc_tag = 0;
    rc_index = 0;
    rc_data = 0;
    rr_ready = 0;
    fifo_read = 0;
    repeat (10) @(posedge clock);
    @(negedge clock);
    chk("rst_rr_valid", 64'(rr_valid), 64'd0);
    chk("rst_interrupt", 64'(interrupt), 64'd0);
    chk("rst_status", status, 64'd0);
    chk("rst_fifo_valid", 64'(fifo_read_valid), 64'd0);
    @(posedge clock) #1;
    reset = 0;
    cyc(30);

    // four requests through pt[0]
    pio_write(32, 64'h1_0000_0000);
    for (int n = 0; n < 4; n++) expect_req(n);
    rr_ready = 1;
    pio_write(0, 64'(4) << 9);
    cyc(20);
    chk("req4_valid_low", 64'(rr_valid), 64'd0);
    chk("req4_count", 64'(req_seen), 64'd4);

    // out-of-order completion, in-order delivery
    for (int n = 0; n < 4; n++) expect_block(n);
    set_read(1);
    send_block(3, 0, 63);
    send_block(1, 0, 63);
    cyc(5);
    chk("pw_hold0", 64'(status[16:0]), 64'd0);
    send_block(0, 0, 63);
    cyc(5);
    chk("pw_step2", 64'(status[16:0]), 64'd2);
    send_block(2, 0, 63);
    cyc(5);
    chk("pw_step4", 64'(status[16:0]), 64'd4);
    drain("drain_first4");
    cyc(20);
    chk("pr_4", 64'(status[33:17]), 64'd4);

    // stalled consumer: window of BLOCKS-1
    set_read(0);
    for (int n = 4; n < 11; n++) expect_req(n);
    pio_write(0, 64'(100) << 9);
    cyc(40);
    chk("win_valid_low", 64'(rr_valid), 64'd0);
    chk("win_count", 64'(req_seen), 64'd11);
    for (int n = 4; n < 12; n++) expect_block(n);
    expect_req(11);
    for (int n = 4; n < 11; n++) send_block(n, 0, 63);
    cyc(20);
    read_n(64);
    cyc(40);
    chk("win_one_more", 64'(req_seen), 64'd12);
    chk("win_valid_low2", 64'(rr_valid), 64'd0);
    pio_write(0, 64'(12) << 9);
    send_block(11, 0, 63);
    set_read(1);
    drain("drain_window");
    cyc(20);
    chk("pw_12", 64'(status[16:0]), 64'd12);

    // flush with three requests outstanding
    for (int n = 12; n < 15; n++) expect_req(n);
    pio_write(0, 64'(15) << 9);
    cyc(20);
    chk("fl_count", 64'(req_seen), 64'd15);
    send_block(12, 0, 31);
    rr_ready = 0;
    pio_write(0, 64'd0);
    pio_write(2, 64'd1);
    send_beat(4, 63, word(99, 63));
    send_beat(5, 63, word(99, 63));
    send_beat(6, 63, word(99, 63));
    repeat (4) @(posedge fifo_clock);
    @(negedge fifo_clock);
    chk("fl_fifo_valid", 64'(fifo_read_valid), 64'd0);
    cyc(10);
    chk("fl_ptrs", 64'(status[33:0]), 64'd0);
`ifdef HIFIFO_FPC_TAG_CHECK_EN
    chk("fl_late_err", 64'(status[63]), 64'd1);
`else
    chk("fl_late_err", 64'(status[63]), 64'd0);
`endif
    pio_write(2, 64'd1);
    rr_ready = 1;
    cyc(40);
    chk("fl_no_req", 64'(rr_valid), 64'd0);
    chk("fl_ptrs2", status, 64'd0);

    // p_int interrupt
    pio_write(1, 64'(2) << 9);
    cyc(3);
    chk("int_idle", 64'(interrupt[0]), 64'd0);
    for (int n = 0; n < 6; n++) begin
      expect_req(n);
      expect_block(n);
    end
    pio_write(0, 64'(6) << 9);
    cyc(20);
    send_block(0, 0, 63);
    send_block(1, 0, 63);
    k = 0;
    while (k < 50) begin
      @(negedge clock);
      if (status[16:0] == 17'd2) break;
      k++;
    end
    chk("int_pw_reached", 64'(status[16:0]), 64'd2);
    chk("int_lat0", 64'(interrupt[0]), 64'd0);
    @(negedge clock);
    chk("int_rise", 64'(interrupt[0]), 64'd1);
    send_block(2, 0, 63);
    send_block(3, 0, 63);
    cyc(10);
    chk("mask_pw4", 64'(status[16:0]), 64'd4);
    pio_write(1, 64'(7) << 9);
    cyc(3);
    chk("int_clear", 64'(interrupt[0]), 64'd0);
    send_block(4, 0, 63);
    send_block(5, 0, 63);
    drain("drain_int");
    cyc(20);
    chk("pw_6", 64'(status[16:0]), 64'd6);
    chk("stop_int", 64'(interrupt[1]), 64'd1);

    // completion for an idle tag
    rr_ready = 0;
    pio_write(0, 64'(10) << 9);
    cyc(3);
    chk("idle_int1", 64'(interrupt[1]), 64'd0);
    send_beat(7, 0, word(77, 0));
    cyc(3);
`ifdef HIFIFO_FPC_TAG_CHECK_EN
    chk("tag_err", 64'(status[63]), 64'd1);
    chk("tag_int1", 64'(interrupt[1]), 64'd1);
`else
    chk("tag_err", 64'(status[63]), 64'd0);
    chk("tag_int1", 64'(interrupt[1]), 64'd0);
`endif
    chk("tag_pw", 64'(status[16:0]), 64'd6);
    cyc(20);
    chk("rr_left", 64'(exp_rr.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
